en_prescaler: RTL

//   Programmable enable generator that sits directly upstream of down_counter and

---
 rtl/en_prescaler.sv | 100 ++++++++++
 1 files changed

// File: rtl/en_prescaler.sv
// Programmable tick generator feeding down_counter.en: one tick every cfg_div+1 clocks,
// continuous or in bursts of cfg_burst ticks. Optional macro: PRESCALER_AUTORELOAD_EN.
module en_prescaler #(
  parameter int DIV_W   = 8,
  parameter int BURST_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [DIV_W-1:0]   cfg_div,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic               start,
  input  logic               stop,
  output logic               tick,
  output logic               busy,
  output logic               done
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t               state, state_nxt;
  logic [DIV_W-1:0]     div_r, div_nxt, phase, phase_nxt;
  logic [BURST_W-1:0]   burst_r, burst_nxt, remaining, remaining_nxt;
  logic                 tick_nxt, done_nxt;
  logic                 cfg_hs;

  assign cfg_ready = (state == IDLE);
  assign busy      = (state == RUN);
  assign cfg_hs    = cfg_valid && cfg_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      div_r     <= '0;
      burst_r   <= '0;
      phase     <= '0;
      remaining <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      div_r     <= div_nxt;
      burst_r   <= burst_nxt;
      phase     <= phase_nxt;
      remaining <= remaining_nxt;
      tick      <= tick_nxt;
      done      <= done_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    div_nxt       = div_r;
    burst_nxt     = burst_r;
    phase_nxt     = phase;
    remaining_nxt = remaining;
    tick_nxt      = 1'b0;
    done_nxt      = 1'b0;
    case (state)
      IDLE: begin
        if (cfg_hs) begin
          div_nxt   = cfg_div;
          burst_nxt = cfg_burst;
        end
        // A config accepted on the start edge takes effect for this run.
        if (start) begin
          state_nxt     = RUN;
          phase_nxt     = cfg_hs ? cfg_div   : div_r;
          remaining_nxt = cfg_hs ? cfg_burst : burst_r;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = IDLE;
        end else if (phase == '0) begin
          tick_nxt  = 1'b1;
          phase_nxt = div_r;
          if (burst_r != '0) begin
            if (remaining <= BURST_W'(1)) begin
              done_nxt = 1'b1;
`ifdef PRESCALER_AUTORELOAD_EN
              remaining_nxt = burst_r;
`else
              remaining_nxt = '0;
              state_nxt     = IDLE;
`endif
            end else begin
              remaining_nxt = remaining - BURST_W'(1);
            end
          end
        end else begin
          phase_nxt = phase - DIV_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
